sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the 128-bit fifo_interface DUT.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem_dp.sv | 45 ++++
 rtl/sync_fifo_param.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
//   fifo_err_t : error event raised in a given cycle (none / overflow / underflow)
//   addr_w()   : address width for a given storage depth
//   FIFO_DEF_* : default width/depth, matching the original 128-bit x16 FIFO
package fifo_pkg;

  localparam int FIFO_DEF_DATA_W = 128;
  localparam int FIFO_DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UNF
  } fifo_err_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage for the FIFO: one write port and one synchronous,
// enabled read port. The array itself is never reset; only the read data
// register is, so the FIFO output comes up as zero.
//   clk      : clock
//   reset    : asynchronous active-low reset of the read register
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, loads rd_data from rd_addr
//   rd_addr  : read address
//   rd_clr   : synchronous clear of the read register
//   rd_data  : registered read data
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DEF_DATA_W,
  parameter int DEPTH  = FIFO_DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a read of the address being written returns the old word,
  // which is what a full FIFO doing simultaneous write+read needs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered flags, fill count, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-
// through output.
//   clk, reset   : clock, asynchronous active-low reset
//   i_flush      : synchronous flush (error flags are kept)
//   i_clr_err    : clears o_overflow / o_underflow
//   i_wren       : write request, i_wrdata the word
//   i_rden       : read request (FWFT: pop of the head word)
//   o_rddata     : read data (FWFT: head word while !o_empty)
//   o_full, o_alm_full, o_empty, o_alm_empty : registered status flags
//   o_count      : entries written and not yet popped
//   o_overflow, o_underflow : sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DEF_DATA_W,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_clr_err,
  input  logic                   i_wren,
  input  logic [DATA_W-1:0]      i_wrdata,
  input  logic                   i_rden,
  output logic [DATA_W-1:0]      o_rddata,
  output logic                   o_full,
  output logic                   o_alm_full,
  output logic                   o_empty,
  output logic                   o_alm_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_MARGIN);

  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic             wr_accept, rd_accept, ram_rd_en, empty_nxt;
  logic [CNT_W-1:0] count_nxt;
  fifo_err_t        err_evt;

  // Flush wins over any request in the same cycle.
  assign rd_accept = i_rden & ~o_empty & ~i_flush;
  assign wr_accept = i_wren & (~o_full | rd_accept) & ~i_flush;

  always_comb begin
    count_nxt = o_count;
    case ({wr_accept, rd_accept})
      2'b10:   count_nxt = o_count + 1'b1;
      2'b01:   count_nxt = o_count - 1'b1;
      default: count_nxt = o_count;
    endcase
  end

  always_comb begin
    err_evt = ERR_NONE;
    if (!i_flush) begin
      if (i_rden && o_empty)         err_evt = ERR_UNF;
      else if (i_wren && !wr_accept) err_evt = ERR_OVF;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The memory read register doubles as the prefetch stage; o_empty is
      // its inverted valid bit. Refill it whenever it is empty or being popped.
      logic ram_has_data;
      assign ram_has_data = (wr_ptr != rd_ptr);
      assign ram_rd_en    = ram_has_data & (o_empty | rd_accept) & ~i_flush;
      assign empty_nxt    = ~(ram_rd_en | (~o_empty & ~rd_accept));
    end else begin : g_std
      assign ram_rd_en = rd_accept;
      assign empty_nxt = (count_nxt == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_alm_full  <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_empty <= 1'b1;
    end else if (i_flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_alm_full  <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_empty <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd_en) rd_ptr <= rd_ptr + 1'b1;
      o_count     <= count_nxt;
      o_full      <= (count_nxt == CNT_FULL);
      o_alm_full  <= (count_nxt >= CNT_AF);
      o_empty     <= empty_nxt;
      o_alm_empty <= (count_nxt <= CNT_AE);
    end
  end

  // A new error in the same cycle as i_clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (err_evt == ERR_OVF) o_overflow <= 1'b1;
      else if (i_clr_err)     o_overflow <= 1'b0;
      if (err_evt == ERR_UNF) o_underflow <= 1'b1;
      else if (i_clr_err)     o_underflow <= 1'b0;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (i_wrdata),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_clr  (i_flush),
    .rd_data (o_rddata)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;

  // standard-mode instance
  logic          flush, clr_err, wren, rden;
  logic [DW-1:0] wrdata;
  logic [DW-1:0] rddata;
  logic          full, alm_full, empty, alm_empty, ovf, unf;
  logic [4:0]    count;

  // FWFT instance
  logic          f_flush, f_clr_err, f_wren, f_rden;
  logic [DW-1:0] f_wrdata;
  logic [DW-1:0] f_rddata;
  logic          f_full, f_alm_full, f_empty, f_alm_empty, f_ovf, f_unf;
  logic [4:0]    f_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .i_flush(flush), .i_clr_err(clr_err),
    .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden), .o_rddata(rddata),
    .o_full(full), .o_alm_full(alm_full), .o_empty(empty), .o_alm_empty(alm_empty),
    .o_count(count), .o_overflow(ovf), .o_underflow(unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .i_flush(f_flush), .i_clr_err(f_clr_err),
    .i_wren(f_wren), .i_wrdata(f_wrdata), .i_rden(f_rden), .o_rddata(f_rddata),
    .o_full(f_full), .o_alm_full(f_alm_full), .o_empty(f_empty), .o_alm_empty(f_alm_empty),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    flush = 0; clr_err = 0; wren = 0; rden = 0; wrdata = '0;
    f_flush = 0; f_clr_err = 0; f_wren = 0; f_rden = 0; f_wrdata = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_empty", empty, 1);
    check("rst_alm_empty", alm_empty, 1);
    check("rst_full", full, 0);
    check("rst_alm_full", alm_full, 0);
    check("rst_count", count, 0);
    check("rst_rddata", rddata, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check("rst_f_empty", f_empty, 1);
    check("rst_f_count", f_count, 0);
    reset = 1'b1;

    // fill with 0..15
    for (int i = 0; i < 16; i++) begin
      wren = 1; wrdata = DW'(i);
      tick();
      check("fill_count", count, DW'(i + 1));
      check("fill_empty", empty, 0);
      check("fill_alm_full", alm_full, (i + 1) >= 14);
      check("fill_full", full, (i + 1) == 16);
    end

    // write while full, no read: dropped
    wrdata = 'h99;
    tick();
    check("ovf_set", ovf, 1);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    wren = 0; clr_err = 1;
    tick();
    check("ovf_clr", ovf, 0);
    clr_err = 0;

    // full: simultaneous write 0xAA + read
    wren = 1; wrdata = 'hAA; rden = 1;
    tick();
    check("wr_rd_full_count", count, 16);
    check("wr_rd_full_full", full, 1);
    check("wr_rd_full_data", rddata, 0);
    check("wr_rd_full_ovf", ovf, 0);
    wren = 0;

    // drain: 1..15 then 0xAA
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("drain_data", rddata, (k < 16) ? DW'(k) : DW'('hAA));
      check("drain_count", count, DW'(16 - k));
      check("drain_alm_empty", alm_empty, (16 - k) <= 2);
      check("drain_empty", empty, (16 - k) == 0);
    end

    // read on empty with simultaneous write: underflow, write still lands
    wren = 1; wrdata = 'h55; rden = 1;
    tick();
    check("unf_set", unf, 1);
    check("unf_count", count, 1);
    check("unf_empty", empty, 0);
    check("unf_data_hold", rddata, 'hAA);
    wren = 0;
    tick();
    check("unf_next_read", rddata, 'h55);
    check("unf_next_count", count, 0);
    check("unf_next_empty", empty, 1);
    rden = 0; clr_err = 1;
    tick();
    check("unf_clr", unf, 0);
    check("idle_hold", rddata, 'h55);
    clr_err = 0;

    // clear and new error in same cycle: error wins
    rden = 1; clr_err = 1;
    tick();
    check("clr_vs_err", unf, 1);
    rden = 0; clr_err = 0;

    // five entries then flush with wr+rd asserted
    for (int i = 0; i < 5; i++) begin
      wren = 1; wrdata = DW'('h10 + i);
      tick();
    end
    check("pre_flush_count", count, 5);
    check("pre_flush_alm_empty", alm_empty, 0);
    flush = 1; wren = 1; rden = 1; wrdata = 'hEE;
    tick();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_alm_empty", alm_empty, 1);
    check("flush_unf_kept", unf, 1);
    check("flush_ovf_kept", ovf, 0);
    check("flush_rddata", rddata, 0);
    flush = 0; wren = 0; rden = 0;

    // some traffic, then reset between edges
    wren = 1; wrdata = 'h77; tick();
    wrdata = 'h78; tick();
    wren = 0; rden = 1; tick();
    check("mid_read", rddata, 'h77);
    check("mid_count", count, 1);
    rden = 0; wren = 1; wrdata = 'h79;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_alm_empty", alm_empty, 1);
    check("mid_rst_rddata", rddata, 0);
    check("mid_rst_unf", unf, 0);
    @(negedge clk);
    wren = 0;
    reset = 1'b1;

    // FWFT: write into empty, head appears after two edges with no read
    f_wren = 1; f_wrdata = 'h1234;
    tick();
    check("fwft_edge1_empty", f_empty, 1);
    check("fwft_edge1_count", f_count, 1);
    f_wren = 0;
    tick();
    check("fwft_edge2_empty", f_empty, 0);
    check("fwft_edge2_data", f_rddata, 'h1234);

    for (int i = 0; i < 3; i++) begin
      f_wren = 1; f_wrdata = DW'('hA1 + i);
      tick();
    end
    f_wren = 0;
    check("fwft_count4", f_count, 4);
    check("fwft_head_held", f_rddata, 'h1234);

    // back-to-back pops stream without bubbles
    f_rden = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fwft_pop_count", f_count, DW'(4 - k));
      check("fwft_pop_empty", f_empty, k == 4);
      if (k < 4) check("fwft_pop_data", f_rddata, DW'('hA0 + k));
    end
    tick();
    check("fwft_unf", f_unf, 1);
    f_rden = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
